// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus of inst_fetch_unit: memory read port, redirect request and the
// decode-facing valid/ready instruction stream.
interface inst_fetch_unit_if;
    logic [31:0] pc_out;
    logic [31:0] inst_in;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        misalign_err;

    // Environment side: instruction memory, branch unit and decode.
    modport master (
        input  pc_out, inst_valid, inst_out, inst_pc, misalign_err,
        output inst_in, fetch_en, redirect_valid, redirect_pc, inst_ready
    );

    // Fetch unit side.
    modport slave (
        output pc_out, inst_valid, inst_out, inst_pc, misalign_err,
        input  inst_in, fetch_en, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: drives the fetch PC, captures the combinational memory word
// and buffers {pc, inst} pairs in a small prefetch FIFO; redirects flush the buffer.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic              clk,
    input logic              rst_n,
    inst_fetch_unit_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic             push, pop;

    // Fullness uses the registered count only: a same-cycle pop never makes room.
    assign push = bus.fetch_en && !bus.redirect_valid && (count_q < DEPTH_CNT);
    assign pop  = (count_q != '0) && bus.inst_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q] <= bus.inst_in;
        end
    end

    assign bus.pc_out       = fetch_pc_q;
    assign bus.inst_valid   = (count_q != '0);
    assign bus.inst_out     = inst_mem_q[rd_ptr_q];
    assign bus.inst_pc      = pc_mem_q[rd_ptr_q];
    assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: queue-based reference model checked every cycle, plus
// directed literal checks for reset, stall, redirect, misalignment and PC wrap.
module tb_inst_fetch_unit;
    localparam int unsigned DEPTH = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    inst_fetch_unit_if bus ();
    inst_fetch_unit_if bus_hi ();

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_hi.slave)
    );

    // Memory holds mem[i] = i, i.e. the word at byte address a is a >> 2.
    assign bus.inst_in    = bus.pc_out >> 2;
    assign bus_hi.inst_in = bus_hi.pc_out >> 2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, inst} plus the next fetch address.
    logic [63:0] mdl_q[$];
    logic [31:0] mdl_pc;
    logic        mdl_err;
    bit          mdl_live = 0;

    always @(posedge clk) begin
        mdl_live = 1;
        if (!rst_n) begin
            mdl_q.delete();
            mdl_pc  = 32'h0000_0000;
            mdl_err = 1'b0;
        end else if (bus.redirect_valid) begin
            mdl_q.delete();
            mdl_pc = {bus.redirect_pc[31:2], 2'b00};
            if (bus.redirect_pc[1:0] != 2'b00) mdl_err = 1'b1;
        end else begin
            bit can_push;
            can_push = bus.fetch_en && (mdl_q.size() < DEPTH);
            if (mdl_q.size() != 0 && bus.inst_ready) void'(mdl_q.pop_front());
            if (can_push) begin
                mdl_q.push_back({mdl_pc, mdl_pc >> 2});
                mdl_pc = mdl_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_live) begin
            check("pc_out", bus.pc_out, mdl_pc);
            check("inst_valid", {31'b0, bus.inst_valid}, {31'b0, mdl_q.size() != 0});
            check("misalign_err", {31'b0, bus.misalign_err}, {31'b0, mdl_err});
            if (mdl_q.size() != 0) begin
                check("inst_pc", bus.inst_pc, mdl_q[0][63:32]);
                check("inst_out", bus.inst_out, mdl_q[0][31:0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    bit [15:0] rdy_pat;
    bit [15:0] en_pat;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.fetch_en = 1'b0;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus_hi.fetch_en = 1'b1;
        bus_hi.inst_ready = 1'b1;
        bus_hi.redirect_valid = 1'b0;
        bus_hi.redirect_pc = 32'h0;
        cyc();
        cyc();

        check("rst pc_out", bus.pc_out, 32'h0);
        check("rst valid", {31'b0, bus.inst_valid}, 32'h0);
        check("rst inst_out", bus.inst_out, 32'h0);
        check("rst inst_pc", bus.inst_pc, 32'h0);
        check("rst err", {31'b0, bus.misalign_err}, 32'h0);
        check("rst hi pc_out", bus_hi.pc_out, 32'hFFFF_FFF8);

        // Streaming with decode always ready.
        rst_n = 1'b1;
        bus.fetch_en = 1'b1;
        bus.inst_ready = 1'b1;
        cyc();
        check("stream0 valid", {31'b0, bus.inst_valid}, 32'h1);
        check("stream0 pc", bus.inst_pc, 32'h0);
        check("stream0 inst", bus.inst_out, 32'h0);
        check("hi0 pc", bus_hi.inst_pc, 32'hFFFF_FFF8);
        cyc();
        check("stream1 pc", bus.inst_pc, 32'h4);
        check("stream1 inst", bus.inst_out, 32'h1);
        check("hi1 pc", bus_hi.inst_pc, 32'hFFFF_FFFC);
        cyc();
        check("stream2 pc", bus.inst_pc, 32'h8);
        check("stream2 inst", bus.inst_out, 32'h2);
        check("hi2 pc", bus_hi.inst_pc, 32'h0000_0000);
        check("hi2 valid", {31'b0, bus_hi.inst_valid}, 32'h1);

        // Stall: decode not ready for 6 cycles after a fresh reset.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        check("stall pc_out", bus.pc_out, 32'h8);
        check("stall inst_pc", bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        check("drain0 pc", bus.inst_pc, 32'h0);
        cyc();
        check("drain1 valid", {31'b0, bus.inst_valid}, 32'h1);
        check("drain1 pc", bus.inst_pc, 32'h4);
        cyc();
        check("drain2 valid", {31'b0, bus.inst_valid}, 32'h1);
        check("drain2 pc", bus.inst_pc, 32'h8);

        // Fill, then redirect to 0x100 while popping the head.
        bus.inst_ready = 1'b0;
        cyc();
        bus.inst_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        check("redir popped pc", bus.inst_pc, 32'h8);
        cyc();
        bus.redirect_valid = 1'b0;
        check("redir N+1 pc_out", bus.pc_out, 32'h100);
        check("redir N+1 valid", {31'b0, bus.inst_valid}, 32'h0);
        cyc();
        check("redir N+2 valid", {31'b0, bus.inst_valid}, 32'h1);
        check("redir N+2 pc", bus.inst_pc, 32'h100);
        check("redir N+2 inst", bus.inst_out, 32'h40);

        // fetch_en low drains the FIFO; a misaligned redirect is still honoured.
        bus.fetch_en = 1'b0;
        cyc();
        cyc();
        check("noen pc_out", bus.pc_out, 32'h104);
        check("noen valid", {31'b0, bus.inst_valid}, 32'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h103;
        cyc();
        bus.redirect_valid = 1'b0;
        bus.fetch_en = 1'b1;
        check("mis pc_out", bus.pc_out, 32'h100);
        check("mis err", {31'b0, bus.misalign_err}, 32'h1);
        cyc();
        check("mis resume pc", bus.inst_pc, 32'h100);
        for (int i = 0; i < 4; i++) cyc();
        check("mis sticky", {31'b0, bus.misalign_err}, 32'h1);

        // Reset with a full FIFO and a pending redirect.
        bus.inst_ready = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h203;
        cyc();
        bus.redirect_valid = 1'b0;
        check("rst2 valid", {31'b0, bus.inst_valid}, 32'h0);
        check("rst2 pc_out", bus.pc_out, 32'h0);
        check("rst2 err", {31'b0, bus.misalign_err}, 32'h0);
        check("rst2 inst_out", bus.inst_out, 32'h0);
        check("rst2 inst_pc", bus.inst_pc, 32'h0);

        // Mixed ready/enable traffic, checked by the model.
        rst_n = 1'b1;
        rdy_pat = 16'b1011_0010_1110_0110;
        en_pat  = 16'b1110_1111_0111_1011;
        for (int i = 0; i < 16; i++) begin
            bus.inst_ready = rdy_pat[i];
            bus.fetch_en = en_pat[i];
            cyc();
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
